// File: rtl/lms_coef_update.sv
// Serial LMS weight-update engine: holds the sample history and TAPS adaptive
// weights, applying w[k] += (e*x[k]) >>> MU_SHIFT one tap per clock.
module lms_coef_update #(
    parameter int TAPS     = 8,
    parameter int DW       = 16,
    parameter int MU_SHIFT = 10
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    sample_valid_i,
    input  logic [DW-1:0]           sample_i,
    input  logic                    err_valid_i,
    input  logic [DW-1:0]           err_i,
    input  logic                    freeze_i,
    input  logic                    clear_i,
    input  logic [$clog2(TAPS)-1:0] coef_rd_addr_i,
    output logic [DW-1:0]           coef_rd_o,
    output logic                    busy_o,
    output logic                    update_done_o,
    output logic                    err_drop_o
);

    localparam int AW = $clog2(TAPS);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    logic [DW-1:0] x_hist [TAPS];
    logic [DW-1:0] x_snap [TAPS];
    logic [DW-1:0] w      [TAPS];
    logic [DW-1:0] err_lat;
    logic [AW-1:0] k;

    logic signed [2*DW-1:0] e_ext;
    logic signed [2*DW-1:0] x_ext;
    logic signed [2*DW-1:0] prod;
    logic signed [2*DW-1:0] delta;
    logic signed [2*DW:0]   sum;
    logic [DW-1:0]          w_next;

    // Saturate when the bits above the DW-bit result are not a pure sign extension.
    always_comb begin
        e_ext = {{DW{err_lat[DW-1]}}, err_lat};
        x_ext = {{DW{x_snap[k][DW-1]}}, x_snap[k]};
        prod  = e_ext * x_ext;
        delta = prod >>> MU_SHIFT;
        sum   = {delta[2*DW-1], delta} + {{(DW+1){w[k][DW-1]}}, w[k]};
        if ((&sum[2*DW:DW-1]) || !(|sum[2*DW:DW-1]))
            w_next = sum[DW-1:0];
        else if (sum[2*DW])
            w_next = {1'b1, {(DW-1){1'b0}}};
        else
            w_next = {1'b0, {(DW-1){1'b1}}};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < TAPS; i++) x_hist[i] <= '0;
        end else if (sample_valid_i) begin
            x_hist[0] <= sample_i;
            for (int unsigned i = 1; i < TAPS; i++) x_hist[i] <= x_hist[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            err_lat       <= '0;
            k             <= '0;
            busy_o        <= 1'b0;
            update_done_o <= 1'b0;
            err_drop_o    <= 1'b0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                w[i]      <= '0;
                x_snap[i] <= '0;
            end
        end else begin
            update_done_o <= 1'b0;
            err_drop_o    <= 1'b0;
            if (clear_i) begin
                state  <= IDLE;
                busy_o <= 1'b0;
                k      <= '0;
                for (int unsigned i = 0; i < TAPS; i++) w[i] <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (err_valid_i && !freeze_i) begin
                            err_lat <= err_i;
                            x_snap  <= x_hist;
                            k       <= '0;
                            busy_o  <= 1'b1;
                            state   <= CALC;
                        end
                    end
                    CALC: begin
                        w[k] <= w_next;
                        k    <= k + AW'(1);
                        if (k == AW'(TAPS - 1)) begin
                            state         <= DONE;
                            update_done_o <= 1'b1;
                        end
                        if (err_valid_i) err_drop_o <= 1'b1;
                    end
                    DONE: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        if (err_valid_i) err_drop_o <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) coef_rd_o <= '0;
        else          coef_rd_o <= w[coef_rd_addr_i];
    end

endmodule

// File: tb/tb_lms_coef_update.sv
// Scoreboard bench for lms_coef_update: a cycle-level reference model predicts
// weights, update-done and drop events; a monitor process checks DUT outputs.
module tb_lms_coef_update;

    localparam int TAPS     = 8;
    localparam int DW       = 16;
    localparam int MU_SHIFT = 10;
    localparam int AW       = $clog2(TAPS);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample = '0;
    logic          err_valid = 1'b0;
    logic [DW-1:0] err = '0;
    logic          freeze = 1'b0;
    logic          clear = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] coef_rd;
    logic          busy;
    logic          done;
    logic          drop;

    always #5 clk = ~clk;

    lms_coef_update #(
        .TAPS     (TAPS),
        .DW       (DW),
        .MU_SHIFT (MU_SHIFT)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .sample_valid_i (sample_valid),
        .sample_i       (sample),
        .err_valid_i    (err_valid),
        .err_i          (err),
        .freeze_i       (freeze),
        .clear_i        (clear),
        .coef_rd_addr_i (rd_addr),
        .coef_rd_o      (coef_rd),
        .busy_o         (busy),
        .update_done_o  (done),
        .err_drop_o     (drop)
    );

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    longint mw [TAPS];
    longint mx [TAPS];
    int     busy_end = 0;
    int     done_q [$];
    int     drop_q [$];
    longint rd_q [$];
    logic   rd_req = 1'b0;
    logic   rd_req_d = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rd_req_d <= rd_req;
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint floor_div(input longint p);
        longint d;
        d = longint'(1) << MU_SHIFT;
        if (p >= 0) return p / d;
        return -((-p + d - 1) / d);
    endfunction

    function automatic longint clamp(input longint v);
        longint hi, lo;
        hi = (longint'(1) << (DW - 1)) - 1;
        lo = -(longint'(1) << (DW - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint rnd_s(input int sh);
        logic signed [DW-1:0] t;
        t = DW'($urandom);
        return longint'(t) / (longint'(1) << sh);
    endfunction

    // One clock: drive inputs for the coming edge and advance the model for it.
    task automatic step(input bit sv, input longint s, input bit ev, input longint e,
                        input bit frz, input bit clr);
        int edge_n;
        @(negedge clk);
        sample_valid = sv;
        sample       = DW'(s);
        err_valid    = ev;
        err          = DW'(e);
        freeze       = frz;
        clear        = clr;
        rd_req       = 1'b0;
        edge_n       = cyc + 1;
        if (clr) begin
            for (int i = 0; i < TAPS; i++) mw[i] = 0;
            if (done_q.size() > 0 && done_q[$] >= edge_n) void'(done_q.pop_back());
            busy_end = edge_n + 1;
        end else if (ev && !frz) begin
            if (edge_n >= busy_end) begin
                for (int i = 0; i < TAPS; i++) mw[i] = clamp(mw[i] + floor_div(e * mx[i]));
                done_q.push_back(edge_n + TAPS);
                busy_end = edge_n + TAPS + 2;
            end else begin
                drop_q.push_back(edge_n);
            end
        end
        if (sv) begin
            for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
            mx[0] = s;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_idle();
        while (cyc + 1 < busy_end) step(0, 0, 0, 0, 0, 0);
        check("busy_after_update", longint'(busy), 0);
    endtask

    task automatic read_all();
        for (int i = 0; i < TAPS; i++) begin
            step(0, 0, 0, 0, 0, 0);
            rd_addr = AW'(i);
            rd_req  = 1'b1;
            rd_q.push_back(mw[i]);
        end
        idle(2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sample_valid = 1'b0; err_valid = 1'b0; freeze = 1'b0; clear = 1'b0; rd_req = 1'b0;
        for (int i = 0; i < TAPS; i++) begin mw[i] = 0; mx[i] = 0; end
        done_q.delete();
        drop_q.delete();
        busy_end = 0;
        #1;
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_drop", longint'(drop), 0);
        check("rst_coef_rd", longint'($signed(coef_rd)), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compares DUT outputs against scoreboard queues as they appear.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (done) begin
                    if (done_q.size() == 0) check("done_unexpected", longint'(done), 0);
                    else check("done_cycle", cyc, done_q.pop_front());
                end
                if (drop) begin
                    if (drop_q.size() == 0) check("drop_unexpected", longint'(drop), 0);
                    else check("drop_cycle", cyc, drop_q.pop_front());
                end
                if (rd_req_d) begin
                    if (rd_q.size() == 0) check("rd_unexpected", longint'(rd_req_d), 0);
                    else check("coef_rd", longint'($signed(coef_rd)), rd_q.pop_front());
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int nbusy, pre, drop_at, clr_at;

        do_reset();
        read_all();

        // Single tap: w[0] = 1024*1024 >>> 10 = 1024, busy for TAPS+1 cycles
        step(1, 1024, 0, 0, 0, 0);
        step(0, 0, 1, 1024, 0, 0);
        nbusy = 0;
        for (int j = 0; j < TAPS + 4; j++) begin
            step(0, 0, 0, 0, 0, 0);
            if (busy) nbusy++;
        end
        check("busy_cycles", nbusy, TAPS + 1);
        wait_idle();
        check("model_w0_1024", mw[0], 1024);
        read_all();

        // Floor rounding toward -inf
        do_reset();
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 1, -1, 0, 0);
        wait_idle();
        read_all();
        step(0, 0, 1, 1, 0, 0);
        wait_idle();
        read_all();

        // Saturation at both rails
        do_reset();
        step(1, 32767, 0, 0, 0, 0);
        for (int j = 0; j < 2; j++) begin step(0, 0, 1, 32767, 0, 0); wait_idle(); end
        read_all();
        for (int j = 0; j < 2; j++) begin step(0, 0, 1, -32768, 0, 0); wait_idle(); end
        read_all();

        // Overrun: second error 3 cycles after the first is dropped
        do_reset();
        step(1, 100, 0, 0, 0, 0);
        step(1, 200, 0, 0, 0, 0);
        step(0, 0, 1, 500, 0, 0);
        idle(2);
        step(0, 0, 1, 300, 0, 0);
        wait_idle();
        read_all();

        // Freeze: error ignored, no busy, no drop
        step(0, 0, 1, 700, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        check("freeze_busy", longint'(busy), 0);
        read_all();

        // Clear at CALC k=3, then a normal update
        step(1, -1234, 0, 0, 0, 0);
        step(0, 0, 1, 9000, 0, 0);
        idle(3);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        check("clear_busy", longint'(busy), 0);
        wait_idle();
        read_all();
        step(1, 3000, 1, 2500, 0, 0);
        wait_idle();
        read_all();

        // Randomized traffic with overruns, clears and samples during CALC
        for (int it = 0; it < 40; it++) begin
            pre     = $urandom_range(0, 3);
            drop_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, TAPS + 2)) : -1;
            clr_at  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, TAPS + 2)) : -1;
            for (int j = 0; j < pre; j++) step(1'($urandom_range(0, 1)), rnd_s(0), 0, 0, 0, 0);
            step(1'($urandom_range(0, 1)), rnd_s(0), 1, rnd_s($urandom_range(0, 6)), 0, 0);
            for (int j = 1; j <= TAPS + 2; j++)
                step(1'($urandom_range(0, 1)), rnd_s(0), j == drop_at, rnd_s(2), 0, j == clr_at);
            wait_idle();
            if (it % 4 == 3) read_all();
        end
        read_all();
        idle(3);

        check("done_pending", done_q.size(), 0);
        check("drop_pending", drop_q.size(), 0);
        check("rd_pending", rd_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
